// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants for the UART command decoder: frame header, FSM encoding,
// and the register map that host frames target.
package uart_cmd_decoder_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  localparam logic [BYTE_W-1:0] CMD_HEAD = 8'hAA;

  // Register addresses already decoded by the downstream register blocks
  localparam logic [ADDR_W-1:0] DDS_EN      = 8'd6;
  localparam logic [ADDR_W-1:0] DDS_FWORD_H = 8'd7;
  localparam logic [ADDR_W-1:0] DDS_FWORD_L = 8'd8;
  localparam logic [ADDR_W-1:0] DDS_PWORD   = 8'd9;

  typedef enum logic [2:0] {
    S_HEAD   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA_H = 3'd2,
    S_DATA_L = 3'd3,
    S_CHK    = 3'd4
  } state_e;

  // Frame checksum: XOR of the three payload bytes
  function automatic logic [BYTE_W-1:0] frame_chk(input logic [BYTE_W-1:0] addr,
                                                  input logic [BYTE_W-1:0] data_h,
                                                  input logic [BYTE_W-1:0] data_l);
    return addr ^ data_h ^ data_l;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder.sv
// Turns the UART receiver byte stream (AA, ADDR, DATA_H, DATA_L, CHK) into
// single-cycle register writes; bad checksums and stalled frames pulse Frame_Err.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter int unsigned CNT_W          = 19
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [BYTE_W-1:0]   Rx_Data,
  input  logic                Rx_Done,
  output logic                m_wr,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wrdata,
  output logic                Frame_Err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   sh_addr_q, sh_addr_d;
  logic [BYTE_W-1:0]   sh_dh_q, sh_dh_d;
  logic [BYTE_W-1:0]   sh_dl_q, sh_dl_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                timeout_c;

  assign timeout_c = (state_q != S_HEAD) && (cnt_q == CNT_LAST);

  // Next-state, shadow capture, timeout and output pulse generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_addr_d = sh_addr_q;
    sh_dh_d   = sh_dh_q;
    sh_dl_d   = sh_dl_q;
    wr_d      = 1'b0;
    err_d     = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;

    if (Rx_Done) begin
      // A byte always wins over a coincident timeout expiry
      cnt_d = '0;
      unique case (state_q)
        S_HEAD: begin
          if (Rx_Data == CMD_HEAD) state_d = S_ADDR;
        end
        S_ADDR: begin
          sh_addr_d = Rx_Data;
          state_d   = S_DATA_H;
        end
        S_DATA_H: begin
          sh_dh_d = Rx_Data;
          state_d = S_DATA_L;
        end
        S_DATA_L: begin
          sh_dl_d = Rx_Data;
          state_d = S_CHK;
        end
        S_CHK: begin
          if (Rx_Data == frame_chk(sh_addr_q, sh_dh_q, sh_dl_q)) begin
            addr_d = ADDR_W'(sh_addr_q);
            data_d = {sh_dh_q, sh_dl_q};
            wr_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_HEAD;
        end
        default: state_d = S_HEAD;
      endcase
    end else if (state_q == S_HEAD) begin
      cnt_d = '0;
    end else if (timeout_c) begin
      state_d = S_HEAD;
      err_d   = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, counter, shadow and output registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_HEAD;
      cnt_q     <= '0;
      sh_addr_q <= '0;
      sh_dh_q   <= '0;
      sh_dl_q   <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_addr_q <= sh_addr_d;
      sh_dh_q   <= sh_dh_d;
      sh_dl_q   <= sh_dl_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign m_wr      = wr_q;
  assign m_addr    = addr_q;
  assign m_wrdata  = data_q;
  assign Frame_Err = err_q;

endmodule
